// File: rtl/leg_ctrl_pkg.sv
// Shared definitions for the multicycle LEGv8 control unit: FSM states,
// instruction classes, ALUop codes and opcode match patterns.
package leg_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // CLS_NONE is the reset value of the latched class; it never reaches EXEC.
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_LD   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_RT   = 3'd3,
        CLS_IMM  = 3'd4,
        CLS_CB   = 3'd5,
        CLS_B    = 3'd6,
        CLS_ILL  = 3'd7
    } cls_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_ZERO  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    // Partial patterns: only the fixed upper bits of each variable-length opcode.
    localparam logic [9:0] OP_ADDI_HI = 10'b1001000100;
    localparam logic [9:0] OP_SUBI_HI = 10'b1101000100;
    localparam logic [5:0] OP_B_HI    = 6'b000101;
    localparam logic [7:0] OP_CBZ_HI  = 8'b10110100;
    localparam logic [7:0] OP_CBNZ_HI = 8'b10110101;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle of run/opcode/handshake inputs and datapath control outputs between
// the multicycle control unit (master) and the datapath/memories (slave).
interface multicycle_control_unit_if #(
    parameter int RETIRE_W = 16
);
    logic                run;
    logic [10:0]         opcode_in;
    logic                imem_ready;
    logic                dmem_ready;
    logic                alu_zero;

    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                reg2Loc;
    logic                ALUsrc;
    logic                memtoReg;
    logic                regWrite;
    logic                memRead;
    logic                memWrite;
    logic [1:0]          ALUop;
    logic                trap;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  run, opcode_in, imem_ready, dmem_ready, alu_zero,
        output imem_req, ir_write, pc_write, pc_src, reg2Loc, ALUsrc,
               memtoReg, regWrite, memRead, memWrite, ALUop, trap, retired
    );

    modport slave (
        output run, opcode_in, imem_ready, dmem_ready, alu_zero,
        input  imem_req, ir_write, pc_write, pc_src, reg2Loc, ALUsrc,
               memtoReg, regWrite, memRead, memWrite, ALUop, trap, retired
    );
endinterface

// File: rtl/leg_opcode_classifier.sv
// Combinational LEGv8 opcode classifier: maps instruction bits [31:21] to an
// instruction class and extracts the CBNZ polarity bit.
module leg_opcode_classifier
    import leg_ctrl_pkg::*;
#(
    parameter int EN_IMM = 1
) (
    input  logic [10:0] i_opcode,
    output cls_t        o_cls,
    output logic        o_cbnz
);

    always_comb begin
        o_cls = CLS_ILL;
        if (i_opcode == OP_LDUR) begin
            o_cls = CLS_LD;
        end else if (i_opcode == OP_STUR) begin
            o_cls = CLS_ST;
        end else if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
                     i_opcode == OP_AND || i_opcode == OP_ORR) begin
            o_cls = CLS_RT;
        end else if (i_opcode[10:1] == OP_ADDI_HI || i_opcode[10:1] == OP_SUBI_HI) begin
            o_cls = (EN_IMM != 0) ? CLS_IMM : CLS_ILL;
        end else if (i_opcode[10:5] == OP_B_HI) begin
            o_cls = CLS_B;
        end else if (i_opcode[10:3] == OP_CBZ_HI || i_opcode[10:3] == OP_CBNZ_HI) begin
            o_cls = CLS_CB;
        end
    end

    // CBZ and CBNZ differ only in this bit; 1 selects branch-on-nonzero.
    assign o_cbnz = i_opcode[3];

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle LEGv8 control FSM: fetch/decode/exec/mem/wb sequencing with
// handshake stalls, a sticky illegal-opcode trap and a retired-instruction count.
module multicycle_control_unit
    import leg_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 16,
    parameter int EN_IMM   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master bus
);

    state_t              r_state;
    state_t              w_next;
    cls_t                r_cls;
    logic                r_cbnz;
    logic [RETIRE_W-1:0] r_retired;

    cls_t       w_dec_cls;
    logic       w_dec_cbnz;
    logic       w_retire;
    logic       w_imem_req;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_reg2loc;
    logic       w_alusrc;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_memread;
    logic       w_memwrite;
    logic [1:0] w_aluop;
    logic       w_trap;

    leg_opcode_classifier #(
        .EN_IMM (EN_IMM)
    ) u_classifier (
        .i_opcode (bus.opcode_in),
        .o_cls    (w_dec_cls),
        .o_cbnz   (w_dec_cbnz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Class is captured in DECODE because opcode_in is only valid there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cls  <= CLS_NONE;
            r_cbnz <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_cls  <= w_dec_cls;
            r_cbnz <= w_dec_cbnz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_imem_req = 1'b0;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        w_pc_src   = 1'b0;
        w_reg2loc  = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_aluop    = ALUOP_ADD;
        w_trap     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_reg2loc = (w_dec_cls == CLS_ST) || (w_dec_cls == CLS_CB);
                w_next    = (w_dec_cls == CLS_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (r_cls)
                    CLS_LD, CLS_ST: begin
                        w_aluop  = ALUOP_ADD;
                        w_alusrc = 1'b1;
                        w_next   = S_MEM;
                    end
                    CLS_RT: begin
                        w_aluop = ALUOP_RTYPE;
                        w_next  = S_WB;
                    end
                    CLS_IMM: begin
                        w_aluop  = ALUOP_IMM;
                        w_alusrc = 1'b1;
                        w_next   = S_WB;
                    end
                    CLS_CB: begin
                        w_aluop    = ALUOP_ZERO;
                        w_pc_write = bus.alu_zero ^ r_cbnz;
                        w_pc_src   = bus.alu_zero ^ r_cbnz;
                        w_retire   = 1'b1;
                        w_next     = bus.run ? S_FETCH : S_IDLE;
                    end
                    CLS_B: begin
                        w_aluop    = ALUOP_ZERO;
                        w_pc_write = 1'b1;
                        w_pc_src   = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = bus.run ? S_FETCH : S_IDLE;
                    end
                    default: w_next = S_IDLE;
                endcase
            end
            S_MEM: begin
                w_memread  = (r_cls == CLS_LD);
                w_memwrite = (r_cls == CLS_ST);
                if (bus.dmem_ready) begin
                    if (r_cls == CLS_LD) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = bus.run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = (r_cls == CLS_LD);
                w_retire   = 1'b1;
                w_next     = bus.run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                w_trap = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.imem_req = w_imem_req;
    assign bus.ir_write = w_ir_write;
    assign bus.pc_write = w_pc_write;
    assign bus.pc_src   = w_pc_src;
    assign bus.reg2Loc  = w_reg2loc;
    assign bus.ALUsrc   = w_alusrc;
    assign bus.memtoReg = w_memtoreg;
    assign bus.regWrite = w_regwrite;
    assign bus.memRead  = w_memread;
    assign bus.memWrite = w_memwrite;
    assign bus.ALUop    = w_aluop;
    assign bus.trap     = w_trap;
    assign bus.retired  = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction cycle traces from a
// behavioural model, compared cycle by cycle against two DUT configurations.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        run, imem_ready, dmem_ready, alu_zero;
    logic [10:0] opcode;
    logic        sel;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.RETIRE_W(16)) ifa ();
    multicycle_control_unit_if #(.RETIRE_W(4))  ifb ();

    assign ifa.run = run;  assign ifa.opcode_in = opcode;
    assign ifa.imem_ready = imem_ready;  assign ifa.dmem_ready = dmem_ready;
    assign ifa.alu_zero = alu_zero;
    assign ifb.run = run;  assign ifb.opcode_in = opcode;
    assign ifb.imem_ready = imem_ready;  assign ifb.dmem_ready = dmem_ready;
    assign ifb.alu_zero = alu_zero;

    multicycle_control_unit #(.RETIRE_W(16), .EN_IMM(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(ifa));
    multicycle_control_unit #(.RETIRE_W(4), .EN_IMM(0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(ifb));

    wire [12:0] obs_a = {ifa.imem_req, ifa.ir_write, ifa.pc_write, ifa.pc_src,
                         ifa.reg2Loc, ifa.ALUsrc, ifa.memtoReg, ifa.regWrite,
                         ifa.memRead, ifa.memWrite, ifa.ALUop, ifa.trap};
    wire [12:0] obs_b = {ifb.imem_req, ifb.ir_write, ifb.pc_write, ifb.pc_src,
                         ifb.reg2Loc, ifb.ALUsrc, ifb.memtoReg, ifb.regWrite,
                         ifb.memRead, ifb.memWrite, ifb.ALUop, ifb.trap};
    wire [12:0] obs     = sel ? obs_b : obs_a;
    wire [15:0] ret_obs = sel ? {12'd0, ifb.retired} : ifa.retired;

    localparam logic [12:0] B_IREQ = 13'h1000, B_IRW = 13'h0800, B_PCW = 13'h0400,
                            B_PCS  = 13'h0200, B_R2L = 13'h0100, B_ASRC = 13'h0080,
                            B_M2R  = 13'h0040, B_RW  = 13'h0020, B_MR  = 13'h0010,
                            B_MW   = 13'h0008, B_TRAP = 13'h0001;

    localparam int K_LD = 1, K_ST = 2, K_RT = 3, K_IMM = 4, K_CB = 5, K_B = 6, K_ILL = 7;
    localparam int NPAT = 11;
    localparam logic [10:0] MSK [NPAT] = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF,
                                           11'h7FE, 11'h7FE, 11'h7E0, 11'h7F8, 11'h7F8};
    localparam logic [10:0] VAL [NPAT] = '{11'b11111000010, 11'b11111000000, 11'b10001011000,
                                           11'b11001011000, 11'b10001010000, 11'b10101010000,
                                           11'b10010001000, 11'b11010001000, 11'b00010100000,
                                           11'b10110100000, 11'b10110101000};
    localparam int KLS [NPAT] = '{K_LD, K_ST, K_RT, K_RT, K_RT, K_RT, K_IMM, K_IMM, K_B, K_CB, K_CB};

    typedef struct {
        logic        run;
        logic        ir;
        logic        dr;
        logic        az;
        logic [10:0] op;
        logic [12:0] exp;
    } cyc_t;

    cyc_t trq[$];
    int   n_cmp = 0, n_fail = 0;
    int   exp_ret = 0;
    int   ret_w = 16;
    bit   from_idle = 1'b1;
    bit   en_imm = 1'b1;

    function automatic int cls_of(logic [10:0] op);
        int k = K_ILL;
        for (int i = 0; i < NPAT; i++)
            if ((op & MSK[i]) == VAL[i]) k = KLS[i];
        if (k == K_IMM && !en_imm) k = K_ILL;
        return k;
    endfunction

    function automatic logic [10:0] pick_op(int idx);
        return VAL[idx] | (11'($urandom) & ~MSK[idx]);
    endfunction

    function automatic void push(logic r, logic ir, logic dr, logic az, logic [10:0] op,
                                 logic [12:0] e);
        cyc_t c;
        c.run = r; c.ir = ir; c.dr = dr; c.az = az; c.op = op; c.exp = e;
        trq.push_back(c);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [15:0] exp_ret_w();
        return 16'(exp_ret & ((1 << ret_w) - 1));
    endfunction

    // Expected per-cycle trace of one instruction, built from the phase rules.
    function automatic void model_instr(logic [10:0] op, int fw, int mw, logic az, logic run_after);
        int          k = cls_of(op);
        logic [12:0] e;
        logic        taken;
        if (from_idle) push(1'b1, rb(), rb(), rb(), 11'($urandom), 13'h0);
        for (int i = 0; i < fw; i++) push(rb(), 1'b0, rb(), rb(), 11'($urandom), B_IREQ);
        push(rb(), 1'b1, rb(), rb(), 11'($urandom), B_IREQ | B_IRW | B_PCW);
        push(rb(), rb(), rb(), rb(), op, (k == K_ST || k == K_CB) ? B_R2L : 13'h0);
        if (k == K_ILL) begin
            from_idle = 1'b0;
            return;
        end
        taken = az ^ op[3];
        case (k)
            K_LD, K_ST: e = B_ASRC | 13'(2'b00 << 1);
            K_RT:       e = 13'(2'b10 << 1);
            K_IMM:      e = B_ASRC | 13'(2'b11 << 1);
            K_CB:       e = 13'(2'b01 << 1) | (taken ? (B_PCW | B_PCS) : 13'h0);
            default:    e = 13'(2'b01 << 1) | B_PCW | B_PCS;
        endcase
        push((k == K_CB || k == K_B) ? run_after : rb(), rb(), rb(),
             (k == K_CB) ? az : rb(), 11'($urandom), e);
        if (k == K_LD || k == K_ST) begin
            e = (k == K_LD) ? B_MR : B_MW;
            for (int i = 0; i < mw; i++) push(rb(), rb(), 1'b0, rb(), 11'($urandom), e);
            push((k == K_ST) ? run_after : rb(), rb(), 1'b1, rb(), 11'($urandom), e);
        end
        if (k == K_LD || k == K_RT || k == K_IMM)
            push(run_after, rb(), rb(), rb(), 11'($urandom), B_RW | ((k == K_LD) ? B_M2R : 13'h0));
        exp_ret++;
        from_idle = !run_after;
    endfunction

    task automatic test_reset();
        sel = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0;
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; alu_zero = 1'b0; opcode = 11'h0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== 13'h0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0", obs); end
        n_cmp++;
        if (ret_obs !== 16'h0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", ret_obs); end
        run = 1'b0; rst_a_n = 1'b1;
        exp_ret = 0; from_idle = 1'b1;
    endtask

    task automatic test_add();
        model_instr(11'b10001011000, 0, 0, 1'b0, 1'b0);
        n_cmp++;
        if (trq.size() != 5) begin n_fail++; $display("FAIL add_len: got %0d want 5", trq.size()); end
        for (int i = 0; i < trq.size(); i++) begin
            @(negedge clk);
            run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
            alu_zero = trq[i].az; opcode = trq[i].op;
            #1; n_cmp++;
            if (obs !== trq[i].exp) begin n_fail++; $display("FAIL add cyc%0d: got %b want %b", i, obs, trq[i].exp); end
        end
        trq.delete();
        @(posedge clk); #1; n_cmp++;
        if (ret_obs !== exp_ret_w()) begin n_fail++; $display("FAIL add_retired: got %0d want %0d", ret_obs, exp_ret_w()); end
    endtask

    task automatic test_ldur_wait();
        model_instr(11'b11111000010, 0, 3, 1'b0, 1'b0);
        for (int i = 0; i < trq.size(); i++) begin
            @(negedge clk);
            run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
            alu_zero = trq[i].az; opcode = trq[i].op;
            #1; n_cmp++;
            if (obs !== trq[i].exp) begin n_fail++; $display("FAIL ldur cyc%0d: got %b want %b", i, obs, trq[i].exp); end
        end
        trq.delete();
        @(posedge clk); #1; n_cmp++;
        if (ret_obs !== exp_ret_w()) begin n_fail++; $display("FAIL ldur_retired: got %0d want %0d", ret_obs, exp_ret_w()); end
    endtask

    task automatic test_cbnz();
        model_instr(pick_op(10), 1, 0, 1'b0, 1'b1);
        model_instr(pick_op(10), 0, 0, 1'b1, 1'b1);
        model_instr(pick_op(9), 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < trq.size(); i++) begin
            @(negedge clk);
            run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
            alu_zero = trq[i].az; opcode = trq[i].op;
            #1; n_cmp++;
            if (obs !== trq[i].exp) begin n_fail++; $display("FAIL cb cyc%0d: got %b want %b", i, obs, trq[i].exp); end
        end
        trq.delete();
        @(posedge clk); #1; n_cmp++;
        if (ret_obs !== exp_ret_w()) begin n_fail++; $display("FAIL cb_retired: got %0d want %0d", ret_obs, exp_ret_w()); end
    endtask

    task automatic test_imm_enabled();
        model_instr(pick_op(6), 0, 0, 1'b0, 1'b1);
        model_instr(pick_op(7), 2, 0, 1'b0, 1'b0);
        for (int i = 0; i < trq.size(); i++) begin
            @(negedge clk);
            run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
            alu_zero = trq[i].az; opcode = trq[i].op;
            #1; n_cmp++;
            if (obs !== trq[i].exp) begin n_fail++; $display("FAIL imm cyc%0d: got %b want %b", i, obs, trq[i].exp); end
        end
        trq.delete();
        @(posedge clk); #1; n_cmp++;
        if (ret_obs !== exp_ret_w()) begin n_fail++; $display("FAIL imm_retired: got %0d want %0d", ret_obs, exp_ret_w()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            model_instr(pick_op($urandom_range(NPAT - 1)), $urandom_range(2), $urandom_range(3),
                        rb(), rb());
            for (int i = 0; i < trq.size(); i++) begin
                @(negedge clk);
                run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
                alu_zero = trq[i].az; opcode = trq[i].op;
                #1; n_cmp++;
                if (obs !== trq[i].exp) begin n_fail++; $display("FAIL rand%0d cyc%0d: got %b want %b", n, i, obs, trq[i].exp); end
            end
            trq.delete();
            @(posedge clk); #1; n_cmp++;
            if (ret_obs !== exp_ret_w()) begin n_fail++; $display("FAIL rand%0d_retired: got %0d want %0d", n, ret_obs, exp_ret_w()); end
        end
    endtask

    task automatic test_illegal(logic [10:0] op, string nm);
        model_instr(op, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < trq.size(); i++) begin
            @(negedge clk);
            run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
            alu_zero = trq[i].az; opcode = trq[i].op;
            #1; n_cmp++;
            if (obs !== trq[i].exp) begin n_fail++; $display("FAIL %s cyc%0d: got %b want %b", nm, i, obs, trq[i].exp); end
        end
        trq.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run = rb(); imem_ready = rb(); dmem_ready = rb(); alu_zero = rb(); opcode = 11'($urandom);
            #1; n_cmp++;
            if (obs !== B_TRAP) begin n_fail++; $display("FAIL %s trap%0d: got %b want %b", nm, i, obs, B_TRAP); end
        end
        n_cmp++;
        if (ret_obs !== exp_ret_w()) begin n_fail++; $display("FAIL %s_retired: got %0d want %0d", nm, ret_obs, exp_ret_w()); end
        @(negedge clk);
        if (sel) rst_b_n = 1'b0; else rst_a_n = 1'b0;
        #1; n_cmp++;
        if (obs !== 13'h0 || ret_obs !== 16'h0) begin
            n_fail++; $display("FAIL %s_reset: got %b/%0d want 0/0", nm, obs, ret_obs);
        end
        run = 1'b0;
        @(negedge clk);
        if (sel) rst_b_n = 1'b1; else rst_a_n = 1'b1;
        exp_ret = 0; from_idle = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        model_instr(11'b11111000010, 0, 3, 1'b0, 1'b1);
        // Play up to and including the first MEM wait cycle, then abort.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
            alu_zero = trq[i].az; opcode = trq[i].op;
            #1; n_cmp++;
            if (obs !== trq[i].exp) begin n_fail++; $display("FAIL midmem cyc%0d: got %b want %b", i, obs, trq[i].exp); end
        end
        trq.delete();
        @(negedge clk);
        run = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b1;
        #1 rst_a_n = 1'b0;
        #1; n_cmp++;
        if (obs !== 13'h0) begin n_fail++; $display("FAIL midmem_async: got %b want 0", obs); end
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1; n_cmp++;
            if (obs !== 13'h0 || ret_obs !== 16'h0) begin
                n_fail++; $display("FAIL midmem_hold%0d: got %b/%0d want 0/0", i, obs, ret_obs);
            end
        end
    endtask

    task automatic test_retire_wrap();
        for (int n = 0; n < 17; n++) model_instr(pick_op(8), 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < trq.size(); i++) begin
            @(negedge clk);
            run = trq[i].run; imem_ready = trq[i].ir; dmem_ready = trq[i].dr;
            alu_zero = trq[i].az; opcode = trq[i].op;
            #1; n_cmp++;
            if (obs !== trq[i].exp) begin n_fail++; $display("FAIL wrap cyc%0d: got %b want %b", i, obs, trq[i].exp); end
        end
        trq.delete();
        @(posedge clk); #1; n_cmp++;
        if (ret_obs !== 16'd1) begin n_fail++; $display("FAIL wrap_retired: got %0d want 1", ret_obs); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_cbnz();
        test_imm_enabled();
        test_random();
        test_illegal(11'b00000000000, "illegal_zero");
        test_reset_mid_mem();
        // Second configuration: 4-bit counter, immediates disabled.
        @(negedge clk);
        sel = 1'b1; en_imm = 1'b0; ret_w = 4; run = 1'b0;
        rst_b_n = 1'b1; exp_ret = 0; from_idle = 1'b1;
        test_illegal(pick_op(6), "addi_disabled");
        test_retire_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
